// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker for a Fibonacci LFSR stream: load, verify, lock, count errors.
// Define PRBS_CHK_BITCNT_EN to build the locked-bit counter behind bit_cnt; otherwise bit_cnt is tied to 0.
module prbs_checker #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] TAPS        = 16'hD008,
    parameter int               LOCK_CNT    = 32,
    parameter int               WINDOW      = 64,
    parameter int               LOSS_THRESH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_bit,
    input  logic        in_valid,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_cnt,
    output logic [31:0] bit_cnt
);

    localparam int LD_W = (WIDTH > 1)    ? $clog2(WIDTH)    : 1;
    localparam int MC_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int WC_W = (WINDOW > 1)   ? $clog2(WINDOW)   : 1;
    localparam int WE_W = $clog2(LOSS_THRESH + 1);

    localparam logic [LD_W-1:0] LD_LAST = LD_W'(WIDTH - 1);
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(LOCK_CNT - 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW - 1);
    localparam logic [WE_W-1:0] WE_LOSS = WE_W'(LOSS_THRESH);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_VERIFY,
        ST_LOCKED
    } state_e;

    state_e          state_q,     state_d;
    logic [WIDTH-1:0] lfsr_q,     lfsr_d;
    logic [LD_W-1:0] load_cnt_q,  load_cnt_d;
    logic [MC_W-1:0] match_cnt_q, match_cnt_d;
    logic [WC_W-1:0] win_cnt_q,   win_cnt_d;
    logic [WE_W-1:0] win_err_q,   win_err_d;
    logic            err_pulse_q, err_pulse_d;
    logic [15:0]     err_cnt_q,   err_cnt_d;

    logic             pred;
    logic             err_hit;
    logic [WIDTH-1:0] shift_in;
    logic [WIDTH-1:0] shift_pred;

    assign pred       = ^(lfsr_q & TAPS);
    assign shift_in   = {lfsr_q[WIDTH-2:0], in_bit};
    assign shift_pred = {lfsr_q[WIDTH-2:0], pred};

    always_comb begin
        // NOTE: every value driven here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        load_cnt_d  = load_cnt_q;
        match_cnt_d = match_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_hit     = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                ST_LOAD: begin
                    lfsr_d = shift_in;
                    if (load_cnt_q == LD_LAST) begin
                        load_cnt_d = '0;
                        if (|shift_in) begin
                            state_d     = ST_VERIFY;
                            match_cnt_d = '0;
                        end
                    end else begin
                        load_cnt_d = load_cnt_q + LD_W'(1);
                    end
                end
                ST_VERIFY: begin
                    lfsr_d = shift_pred;
                    if (in_bit == pred) begin
                        if (match_cnt_q == MC_LAST) begin
                            state_d     = ST_LOCKED;
                            match_cnt_d = '0;
                            win_cnt_d   = '0;
                            win_err_d   = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + MC_W'(1);
                        end
                    end else begin
                        state_d    = ST_LOAD;
                        load_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // The state keeps free-running on its own prediction so received errors never corrupt it.
                    lfsr_d  = shift_pred;
                    err_hit = (in_bit != pred);
                    if (win_cnt_q == WC_LAST) begin
                        win_cnt_d = '0;
                        win_err_d = WE_W'(err_hit);
                    end else begin
                        win_cnt_d = win_cnt_q + WC_W'(1);
                        win_err_d = win_err_q + WE_W'(err_hit);
                    end
                    if (win_err_d == WE_LOSS) begin
                        state_d    = ST_LOAD;
                        load_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                end
            endcase
        end

        err_pulse_d = err_hit;
        if (clear) begin
            err_cnt_d = {15'd0, err_hit};
        end else if (err_hit && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            lfsr_q      <= '0;
            load_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            load_cnt_q  <= load_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] bit_cnt_q, bit_cnt_d;
    logic        bit_hit;

    always_comb begin
        bit_hit = in_valid && (state_q == ST_LOCKED);
        if (clear) begin
            bit_cnt_d = {31'd0, bit_hit};
        end else if (bit_hit) begin
            bit_cnt_d = bit_cnt_q + 32'd1;
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_cnt = bit_cnt_q;
`else
    assign bit_cnt = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: stimulus queues the expected response per transaction, a monitor compares.
// A second instance with an unreachable loss threshold exercises err_cnt saturation.
`timescale 1ns/1ps
module tb_prbs_checker;

    localparam logic [15:0] TAPS = 16'hD008;
`ifdef PRBS_CHK_BITCNT_EN
    localparam bit BITCNT = 1'b1;
`else
    localparam bit BITCNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_bit, in_valid, clear;
    logic        locked, err_pulse;
    logic [15:0] err_cnt;
    logic [31:0] bit_cnt;

    logic        in_bit_s, in_valid_s, clear_s;
    logic        locked_s, err_pulse_s;
    logic [15:0] err_cnt_s;
    logic [31:0] bit_cnt_s;

    prbs_checker dut (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
    );

    prbs_checker #(.LOSS_THRESH(255)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit_s), .in_valid(in_valid_s), .clear(clear_s),
        .locked(locked_s), .err_pulse(err_pulse_s), .err_cnt(err_cnt_s), .bit_cnt(bit_cnt_s)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        locked;
        logic        err_pulse;
        logic [15:0] err_cnt;
        logic [31:0] bit_cnt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int          n_seen   = 0;
    logic [15:0] gen;
    logic        cur_locked;
    logic [15:0] exp_err;
    logic [31:0] exp_bits;
    int          since_lock;
    bit          gaps;
    logic        pending;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one response per accepted transaction (valid bit or clear).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= 1'b0;
        else        pending <= in_valid | clear;
    end

    always @(negedge clk) begin
        if (pending) begin
            if (sb_q.size() == 0) begin
                check($sformatf("sb_underflow@%0d", n_seen), 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check($sformatf("locked@%0d", n_seen),    {63'd0, locked},    {63'd0, mon_e.locked});
                check($sformatf("err_pulse@%0d", n_seen), {63'd0, err_pulse}, {63'd0, mon_e.err_pulse});
                check($sformatf("err_cnt@%0d", n_seen),   {48'd0, err_cnt},   {48'd0, mon_e.err_cnt});
                check($sformatf("bit_cnt@%0d", n_seen),   {32'd0, bit_cnt},   {32'd0, mon_e.bit_cnt});
            end
            n_seen++;
        end
    end

    task automatic gen_next(output logic b);
        b   = ^(gen & TAPS);
        gen = {gen[14:0], b};
    endtask

    task automatic drive(input logic v, input logic b, input logic clr, input logic lk_after, input logic pulse);
        logic counted;
        exp_t e;
        counted = v & cur_locked;
        if (clr) begin
            exp_err  = {15'd0, pulse};
            exp_bits = {31'd0, counted};
        end else begin
            if (pulse && exp_err != 16'hFFFF) exp_err++;
            if (counted) exp_bits++;
        end
        if (counted) since_lock++;
        if (lk_after && !cur_locked) since_lock = 0;
        e.locked    = lk_after;
        e.err_pulse = pulse;
        e.err_cnt   = exp_err;
        e.bit_cnt   = BITCNT ? exp_bits : 32'd0;
        sb_q.push_back(e);
        @(negedge clk);
        in_valid   = v;
        in_bit     = b;
        clear      = clr;
        cur_locked = lk_after;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0;
                clear    = 1'b0;
            end
        end
    endtask

    // Next generator bit, optionally inverted; an inversion counts as an error only when already locked.
    task automatic pb(input logic inv, input logic lk_after);
        logic b;
        gen_next(b);
        drive(1'b1, b ^ inv, 1'b0, lk_after, inv & cur_locked);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            clear    = 1'b0;
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        cur_locked = 1'b0;
        exp_err    = '0;
        exp_bits   = '0;
        #1;
        check("async_reset", {locked, err_pulse, err_cnt, bit_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic b;
        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clear = 1'b0;
        in_valid_s = 1'b0; in_bit_s = 1'b0; clear_s = 1'b0;
        gen = 16'hACE1; cur_locked = 1'b0; exp_err = '0; exp_bits = '0;
        since_lock = 0; gaps = 1'b0;

        #12;
        check("reset_state", {locked, err_pulse, err_cnt, bit_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check($sformatf("idle@%0d", i), {locked, err_pulse, err_cnt, bit_cnt}, 64'd0);
        end

        // Clean stream: lock after exactly 48 bits, continuous then gapped.
        for (int i = 0; i < 1000; i++) begin
            gaps = (i >= 500);
            pb(1'b0, i >= 47);
        end
        gaps = 1'b0;
        idle(2);
        check("clean_err_cnt", {48'd0, err_cnt}, 64'd0);
        check("clean_bit_cnt", {32'd0, bit_cnt}, BITCNT ? 64'd952 : 64'd0);

        // Single inverted bit: one pulse, lock held, later bits all match.
        for (int i = 0; i < 300; i++) pb(i == 200, 1'b1);
        idle(2);
        check("single_err_cnt", {48'd0, err_cnt}, 64'd1);

        // Seven errors in each of two consecutive windows keep lock.
        while (since_lock % 64 != 10) pb(1'b0, 1'b1);
        for (int k = 0; k < 7; k++) pb(1'b1, 1'b1);
        while (since_lock % 64 != 10) pb(1'b0, 1'b1);
        for (int k = 0; k < 7; k++) pb(1'b1, 1'b1);
        for (int k = 0; k < 20; k++) pb(1'b0, 1'b1);

        // Eight errors in one window drop lock, then 48 clean bits relock.
        while (since_lock % 64 != 20) pb(1'b0, 1'b1);
        for (int k = 0; k < 8; k++) pb(1'b1, k < 7);
        for (int j = 0; j < 48; j++) pb(1'b0, j >= 47);
        idle(2);
        check("relock_err_cnt", {48'd0, err_cnt}, 64'd23);

        // Clear on the same edge as an error leaves 1; clear alone leaves 0.
        pb(1'b1, 1'b1);
        pb(1'b1, 1'b1);
        gen_next(b);
        drive(1'b1, ~b, 1'b1, 1'b1, 1'b1);
        pb(1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        pb(1'b0, 1'b1);
        idle(3);
        check("sb_drain_1", sb_q.size(), 64'd0);

        // Reset mid-operation, then all-zero and garbage input never lock.
        reset_pulse();
        for (int i = 0; i < 500; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 500; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        idle(2);

        // After reset the first valid bit is load bit 0.
        reset_pulse();
        gen = 16'h1234;
        for (int j = 0; j < 48; j++) pb(1'b0, j >= 47);
        idle(3);
        check("sb_drain_2", sb_q.size(), 64'd0);

        // Saturation on the high-threshold instance: lock, then every bit is an error.
        gen = 16'hBEEF;
        for (int j = 0; j < 48; j++) begin
            gen_next(b);
            @(negedge clk);
            in_valid_s = 1'b1;
            in_bit_s   = b;
        end
        for (int n = 1; n <= 65540; n++) begin
            gen_next(b);
            @(negedge clk);
            if (n == 1)     check("sat_locked", {63'd0, locked_s}, 64'd1);
            if (n == 65535) check("sat_fffe", {48'd0, err_cnt_s}, 64'hFFFE);
            if (n == 65536) check("sat_ffff", {48'd0, err_cnt_s}, 64'hFFFF);
            in_valid_s = 1'b1;
            in_bit_s   = ~b;
        end
        @(negedge clk);
        in_valid_s = 1'b0;
        check("sat_hold", {48'd0, err_cnt_s}, 64'hFFFF);
        check("sat_pulse", {63'd0, err_pulse_s}, 64'd1);
        check("sat_still_locked", {63'd0, locked_s}, 64'd1);
        check("sat_bit_cnt", {32'd0, bit_cnt_s}, BITCNT ? 64'd65540 : 64'd0);
        @(negedge clk);
        check("sat_pulse_drop", {63'd0, err_pulse_s}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
